// File: rtl/hash_matcher.sv
// Qualifies md5core digests with a delayed enable, compares them to a loaded target,
// and holds the first matching message block plus checked/matched statistics.
module hash_matcher #(
  parameter int unsigned LATENCY = 65
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [127:0] hash,
  input  logic [511:0] message_in,
  input  logic [127:0] target,
  input  logic         target_load,
  input  logic         ack,
  output logic         found,
  output logic [511:0] found_message,
  output logic [63:0]  checked_count,
  output logic [15:0]  match_count,
  output logic         searching
);

  typedef enum logic [1:0] {IDLE, SEARCH, FOUND} state_t;

  state_t               state;
  logic [LATENCY-1:0]   vpipe;
  logic [127:0]         target_reg;
  logic                 hv;
  logic                 hit;
  logic [63:0]          checked_next;
  logic [15:0]          match_next;

  assign hv  = vpipe[LATENCY-1];
  assign hit = hv && (hash == target_reg);

  always_comb begin
    checked_next = (&checked_count) ? checked_count : checked_count + 64'd1;
    match_next   = (&match_count)   ? match_count   : match_count + 16'd1;
  end

  // Loop form keeps LATENCY == 1 legal, where a concatenation slice would be empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= enable;
      for (int unsigned i = 1; i < LATENCY; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      target_reg    <= '0;
      found         <= 1'b0;
      found_message <= '0;
      checked_count <= '0;
      match_count   <= '0;
      searching     <= 1'b0;
    end else if (target_load) begin
      // The comparison made this cycle used the old target and is deliberately dropped.
      state         <= SEARCH;
      target_reg    <= target;
      found         <= 1'b0;
      found_message <= '0;
      checked_count <= '0;
      match_count   <= '0;
      searching     <= 1'b1;
    end else begin
      case (state)
        SEARCH: begin
          if (hv) checked_count <= checked_next;
          if (hit) begin
            match_count   <= match_next;
            found_message <= message_in;
            found         <= 1'b1;
            state         <= FOUND;
            searching     <= 1'b0;
          end
        end
        FOUND: begin
          if (hv)  checked_count <= checked_next;
          if (hit) match_count   <= match_next;
          if (ack) begin
            if (hit) begin
              found_message <= message_in;
            end else begin
              found     <= 1'b0;
              state     <= SEARCH;
              searching <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          searching <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_matcher.sv
// Directed bench for hash_matcher: digests are driven directly with hand-placed
// timing relative to the enable pulses, LATENCY cycles later.
module tb_hash_matcher;
  localparam int unsigned LAT = 65;

  logic         clk = 1'b0;
  logic         reset, enable, target_load, ack;
  logic [127:0] hash, target;
  logic [511:0] message_in;
  logic         found, searching;
  logic [511:0] found_message;
  logic [63:0]  checked_count;
  logic [15:0]  match_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] t0, t1, nohit;
  logic [511:0] blk_a, blk_b, blk_c, blk_d;

  hash_matcher #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .hash(hash), .message_in(message_in),
    .target(target), .target_load(target_load), .ack(ack), .found(found),
    .found_message(found_message), .checked_count(checked_count),
    .match_count(match_count), .searching(searching)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] t);
    target = t; target_load = 1'b1;
    tick();
    target_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; target_load = 1'b0; ack = 1'b0;
    hash = '0; message_in = '0; target = '0;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (found !== 1'b0) begin n_bad++; $display("FAIL reset_found: got %b want 0", found); end
    n_cmp++; if (found_message !== 512'd0) begin n_bad++; $display("FAIL reset_msg: got %h want 0", found_message); end
    n_cmp++; if (checked_count !== 64'd0) begin n_bad++; $display("FAIL reset_checked: got %0d want 0", checked_count); end
    n_cmp++; if (match_count !== 16'd0) begin n_bad++; $display("FAIL reset_match: got %0d want 0", match_count); end
    n_cmp++; if (searching !== 1'b0) begin n_bad++; $display("FAIL reset_searching: got %b want 0", searching); end
    // hash 0 equals the reset target, but IDLE must not compare
    enable = 1'b1;
    repeat (100) tick();
    enable = 1'b0;
    repeat (LAT + 2) tick();
    n_cmp++; if (found !== 1'b0) begin n_bad++; $display("FAIL idle_found: got %b want 0", found); end
    n_cmp++; if (checked_count !== 64'd0) begin n_bad++; $display("FAIL idle_checked: got %0d want 0", checked_count); end
    n_cmp++; if (match_count !== 16'd0) begin n_bad++; $display("FAIL idle_match: got %0d want 0", match_count); end
    n_cmp++; if (searching !== 1'b0) begin n_bad++; $display("FAIL idle_searching: got %b want 0", searching); end
  endtask

  task automatic test_match();
    hash = nohit;
    load(t0);
    n_cmp++; if (searching !== 1'b1) begin n_bad++; $display("FAIL load_searching: got %b want 1", searching); end
    enable = 1'b1; tick(); enable = 1'b0;
    repeat (LAT - 1) tick();
    hash = t0; message_in = blk_a;
    n_cmp++; if (found !== 1'b0) begin n_bad++; $display("FAIL match_early: got %b want 0", found); end
    tick();
    hash = nohit; message_in = '0;
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL match_found: got %b want 1", found); end
    n_cmp++; if (found_message !== blk_a) begin n_bad++; $display("FAIL match_msg: got %h want %h", found_message, blk_a); end
    n_cmp++; if (checked_count !== 64'd1) begin n_bad++; $display("FAIL match_checked: got %0d want 1", checked_count); end
    n_cmp++; if (match_count !== 16'd1) begin n_bad++; $display("FAIL match_count: got %0d want 1", match_count); end
    n_cmp++; if (searching !== 1'b0) begin n_bad++; $display("FAIL match_searching: got %b want 0", searching); end
  endtask

  task automatic test_no_match();
    hash = nohit;
    load(t0);
    enable = 1'b1;
    repeat (100) tick();
    enable = 1'b0;
    repeat (LAT - 1) tick();
    n_cmp++; if (checked_count !== 64'd99) begin n_bad++; $display("FAIL nomatch_checked99: got %0d want 99", checked_count); end
    tick();
    n_cmp++; if (checked_count !== 64'd100) begin n_bad++; $display("FAIL nomatch_checked100: got %0d want 100", checked_count); end
    repeat (5) tick();
    n_cmp++; if (checked_count !== 64'd100) begin n_bad++; $display("FAIL nomatch_hold: got %0d want 100", checked_count); end
    n_cmp++; if (found !== 1'b0) begin n_bad++; $display("FAIL nomatch_found: got %b want 0", found); end
    n_cmp++; if (match_count !== 16'd0) begin n_bad++; $display("FAIL nomatch_match: got %0d want 0", match_count); end
  endtask

  task automatic test_found_behaviour();
    hash = nohit;
    load(t0);
    ack = 1'b1; tick(); ack = 1'b0;
    n_cmp++; if (searching !== 1'b1) begin n_bad++; $display("FAIL ack_search_ignored: got %b want 1", searching); end
    enable = 1'b1; tick(); tick(); enable = 1'b0;
    repeat (LAT - 2) tick();
    hash = t0; message_in = blk_a; tick();
    message_in = blk_b; tick();
    hash = nohit; message_in = '0;
    n_cmp++; if (found_message !== blk_a) begin n_bad++; $display("FAIL found_keep_msg: got %h want %h", found_message, blk_a); end
    n_cmp++; if (match_count !== 16'd2) begin n_bad++; $display("FAIL found_match2: got %0d want 2", match_count); end
    n_cmp++; if (checked_count !== 64'd2) begin n_bad++; $display("FAIL found_checked2: got %0d want 2", checked_count); end
    ack = 1'b1; tick(); ack = 1'b0;
    n_cmp++; if (found !== 1'b0) begin n_bad++; $display("FAIL ack_clear: got %b want 0", found); end
    n_cmp++; if (searching !== 1'b1) begin n_bad++; $display("FAIL ack_searching: got %b want 1", searching); end
    enable = 1'b1; tick(); tick(); enable = 1'b0;
    repeat (LAT - 2) tick();
    hash = t0; message_in = blk_c; tick();
    message_in = blk_d; ack = 1'b1; tick();
    ack = 1'b0; hash = nohit; message_in = '0;
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL ackhit_found: got %b want 1", found); end
    n_cmp++; if (found_message !== blk_d) begin n_bad++; $display("FAIL ackhit_msg: got %h want %h", found_message, blk_d); end
    n_cmp++; if (match_count !== 16'd4) begin n_bad++; $display("FAIL ackhit_match4: got %0d want 4", match_count); end
    n_cmp++; if (searching !== 1'b0) begin n_bad++; $display("FAIL ackhit_searching: got %b want 0", searching); end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_load_vs_hit();
    hash = nohit;
    load(t0);
    enable = 1'b1; tick(); enable = 1'b0;
    repeat (LAT - 1) tick();
    hash = t0; message_in = blk_a; target = t1; target_load = 1'b1;
    tick();
    target_load = 1'b0; hash = nohit; message_in = '0;
    n_cmp++; if (found !== 1'b0) begin n_bad++; $display("FAIL loadhit_found: got %b want 0", found); end
    n_cmp++; if (checked_count !== 64'd0) begin n_bad++; $display("FAIL loadhit_checked: got %0d want 0", checked_count); end
    n_cmp++; if (match_count !== 16'd0) begin n_bad++; $display("FAIL loadhit_match: got %0d want 0", match_count); end
    n_cmp++; if (searching !== 1'b1) begin n_bad++; $display("FAIL loadhit_searching: got %b want 1", searching); end
    // old target must now miss, new target must hit
    enable = 1'b1; tick(); tick(); enable = 1'b0;
    repeat (LAT - 2) tick();
    hash = t0; message_in = blk_b; tick();
    hash = t1; message_in = blk_c; tick();
    hash = nohit; message_in = '0;
    n_cmp++; if (found_message !== blk_c) begin n_bad++; $display("FAIL newtarget_msg: got %h want %h", found_message, blk_c); end
    n_cmp++; if (match_count !== 16'd1) begin n_bad++; $display("FAIL newtarget_match: got %0d want 1", match_count); end
    n_cmp++; if (checked_count !== 64'd2) begin n_bad++; $display("FAIL newtarget_checked: got %0d want 2", checked_count); end
  endtask

  task automatic test_reset_in_flight();
    hash = t0; message_in = blk_a;
    enable = 1'b1;
    repeat (10) tick();
    enable = 1'b0;
    repeat (20) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++; if (found_message !== 512'd0) begin n_bad++; $display("FAIL rst2_msg: got %h want 0", found_message); end
    n_cmp++; if (searching !== 1'b0) begin n_bad++; $display("FAIL rst2_searching: got %b want 0", searching); end
    load(t0);
    repeat (50) tick();
    n_cmp++; if (found !== 1'b0) begin n_bad++; $display("FAIL inflight_found: got %b want 0", found); end
    n_cmp++; if (checked_count !== 64'd0) begin n_bad++; $display("FAIL inflight_checked: got %0d want 0", checked_count); end
    n_cmp++; if (match_count !== 16'd0) begin n_bad++; $display("FAIL inflight_match: got %0d want 0", match_count); end
    n_cmp++; if (searching !== 1'b1) begin n_bad++; $display("FAIL inflight_searching: got %b want 1", searching); end
  endtask

  initial begin
    t0    = 128'h098f6bcd4621d373cade4e832627b4f6;
    t1    = 128'h5d41402abc4b2a76b9719d911017c592;
    nohit = 128'h0123456789abcdef0123456789abcdef;
    blk_a = '0; blk_a[31:0] = 32'h74657374; blk_a[39:32] = 8'h80; blk_a[511:448] = 64'd32;
    blk_b = blk_a; blk_b[31:0] = 32'h74657375;
    blk_c = blk_a; blk_c[31:0] = 32'h74657376;
    blk_d = blk_a; blk_d[31:0] = 32'h74657377;
    test_reset();
    test_match();
    test_no_match();
    test_found_behaviour();
    test_load_vs_hit();
    test_reset_in_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hash_matcher.md
# hash_matcher

Downstream consumer of the pipelined `md5core` in the hash-breaker datapath. It tracks which `md5core` outputs are real, because the core carries no valid signal: an `enable` bit is delayed by the core's fixed latency. Each valid digest is compared against a loaded target hash, and the matching 512-bit padded message block is captured. The block reports a sticky `found` to the host and to the upstream candidate generator, and keeps checked/matched statistics.

## Interface
- `LATENCY`, default 65: cycles from a candidate on `md5core.message` to its digest on `md5core.hash`.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `enable`  in  1  upstream presented a valid candidate to `md5core` this cycle.
- `hash`  in  128  digest from `md5core.hash`.
- `message_in`  in  512  padded block from `md5core.message_out`, aligned with `hash`.
- `target`  in  128  target digest; sampled only when `target_load`=1.
- `target_load`  in  1  load `target` and (re)start the search.
- `ack`  in  1  host consumed the result; clears `found`.
- `found`  out  1  registered; a match is held.
- `found_message`  out  512  registered; block that produced the held match.
- `checked_count`  out  64  valid digests compared since the last load; saturates at 2^64-1.
- `match_count`  out  16  matches since the last load, including ones not captured; saturates at 0xFFFF.
- `searching`  out  1  registered; state == SEARCH.

## Operation
- Valid tracking: `LATENCY`-bit shift register `vpipe`; `vpipe[0]`<=`enable` each cycle. `hv` = `vpipe[LATENCY-1]` marks `hash`/`message_in` as valid this cycle.
- `target_reg` (128 b) is loaded when `target_load`=1.
- `hit` = `hv` & (`hash` == `target_reg`), full 128-bit equality.
- FSM states:
  - IDLE (reset state): no comparisons, counters frozen. `target_load` -> SEARCH.
  - SEARCH: on `hv`, `checked_count`++. On `hit`, `match_count`++, capture `message_in` into `found_message`, set `found`, go to FOUND.
  - FOUND: `found`=1. `hv` still increments `checked_count`, and `hit` still increments `match_count`. `found_message` is not overwritten. `ack` -> SEARCH with `found`=0.
- `target_load` in any state:
  - target_reg <= `target`;
  - `found`, `found_message`, `checked_count` and `match_count` <= 0;
  - go to SEARCH.
  - The comparison in that cycle is discarded, even though it used the old target.
  - `vpipe` is not flushed, so in-flight candidates are compared against the new target.
- `ack` together with `hit` in FOUND: the new match wins. Capture the new `message_in`, keep `found`=1, stay in FOUND, and increment `match_count`.
- `ack` in IDLE or SEARCH is ignored.
- Priority: `reset` > `target_load` > `hit`/`ack`.
- Reset: state IDLE, `vpipe`=0, `target_reg`=0, and every output 0. Candidates in flight at reset are never counted.

## Timing
- Candidate with `enable`=1 at cycle T: `hv`=1 at cycle T+`LATENCY`.
  - On a hit, `found`, `found_message` and `match_count` update at the T+`LATENCY` edge and are visible in cycle T+`LATENCY`+1.
  - `checked_count` updates on the same edge.
- `target_load` at cycle L: the new `target_reg` and zeroed outputs are visible in L+1, with `searching`=1 in L+1. Digests with `hv` in L+1 or later are compared against the new target.
- `ack` at cycle A: `found`=0 in A+1, unless a concurrent hit occurs.
- Throughput: one comparison per cycle, no stalls. `found` may be used by upstream as a halt, so the bench must tolerate up to `LATENCY` further valid digests after a match.

## Test plan
- Reset, then drive `hash`=0 with `enable`=1 for 100 cycles and no `target_load` -> all outputs stay 0 and `searching`=0.
- Load target 0x098f6bcd4621d373cade4e832627b4f6 (MD5 "test"). Pulse `enable` at T. At T+65 present that hash and a block with low bytes "test" -> `found`=1 at T+66, `found_message` equals the block, `checked_count`=1, `match_count`=1.
- `enable` high for 100 cycles with no match -> `checked_count`=100 after the last digest, `found`=0, `match_count`=0.
- In FOUND, present a second matching digest with a different block -> `found_message` unchanged, `match_count`=2. `ack` with no hit -> `found`=0 next cycle. `ack` plus a hit -> `found` stays 1 and the new block is captured.
- `target_load` in the same cycle as a hit against the old target -> next cycle `found`=0, counts=0, `searching`=1, and `target_reg` equals the new value.
- `enable` high for 10 cycles, `reset` at cycle 30, then reload the target. The matching digests arrive at cycles 65-74 -> no count and no `found`.
